spi_cmd_rx: RTL and testbench

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

---
 rtl/spi_cmd_rx.sv | 197 +++++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command receiver: frames an opcode plus a fixed-length payload
// from an asynchronous SPI slave port and commits command / time-preset fields.
`timescale 1ns/1ps
module spi_cmd_rx #(
    parameter logic [7:0] CMD_OPC  = 8'h01,
    parameter logic [7:0] TIME_OPC = 8'h02
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        SCK,
    input  logic        CS_n,
    input  logic        MOSI,
    input  logic        SYS_TIME_UPDATE_OK,
    output logic [47:0] FREQ,
    output logic [47:0] FREQ_STEP,
    output logic [31:0] FREQ_RATE,
    output logic [63:0] TIME_START,
    output logic [15:0] N_impulse,
    output logic [1:0]  TYPE_impulse,
    output logic [31:0] Interval_Ti,
    output logic [31:0] Interval_Tp,
    output logic [31:0] Tblank1,
    output logic [31:0] Tblank2,
    output logic        SPI_WR,
    output logic [63:0] TIME_INIT,
    output logic        SYS_TIME_UPDATE,
    output logic [7:0]  ERR_CNT
);

    localparam int unsigned CMD_BITS  = 344;
    localparam int unsigned TIME_BITS = 64;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned CNT_MAX   = 345;
    localparam int unsigned HI_W      = 208;
    localparam int unsigned LO_W      = 128;

    typedef enum logic [2:0] {IDLE, OPCODE, PAYLOAD, DRAIN, COMMIT} state_e;

    state_e              state_q, state_d;
    logic [2:0]          sck_q, cs_q;
    logic [1:0]          mosi_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc, pay_len;
    logic [CMD_BITS-1:0] shift_q, shift_d;
    logic                is_cmd_q, is_cmd_d;
    logic [HI_W-1:0]     hi_q, hi_d;
    logic [1:0]          type_q, type_d;
    logic [LO_W-1:0]     lo_q, lo_d;
    logic [63:0]         time_q, time_d;
    logic                upd_q, upd_d;
    logic                wr_q, wr_d;
    logic [7:0]          err_q, err_d;
    logic                err_inc;

    logic       sck_rise, cs_rise, cs_fall, bit_in, mosi_s;
    logic [7:0] opc_c;

    // Edge detection on the synchronized pins (stage 1 is the second sync flop)
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign mosi_s   = mosi_q[1];
    assign bit_in   = sck_rise & ~cs_q[1];
    assign opc_c    = {shift_q[6:0], mosi_s};
    assign pay_len  = is_cmd_q ? CNT_W'(CMD_BITS) : CNT_W'(TIME_BITS);
    assign cnt_inc  = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        is_cmd_d = is_cmd_q;
        hi_d     = hi_q;
        type_d   = type_q;
        lo_d     = lo_q;
        time_d   = time_q;
        upd_d    = upd_q & ~SYS_TIME_UPDATE_OK;
        wr_d     = 1'b0;
        err_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = OPCODE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            OPCODE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end else if (bit_in) begin
                    shift_d = {shift_q[CMD_BITS-2:0], mosi_s};
                    cnt_d   = cnt_inc;
                    if (cnt_q == CNT_W'(7)) begin
                        if (opc_c == CMD_OPC || opc_c == TIME_OPC) begin
                            state_d  = PAYLOAD;
                            is_cmd_d = (opc_c == CMD_OPC);
                            cnt_d    = '0;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (cs_rise) begin
                    if (cnt_q == pay_len) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_inc = 1'b1;
                    end
                end else if (bit_in) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == pay_len) begin
                        state_d = DRAIN;
                    end else begin
                        shift_d = {shift_q[CMD_BITS-2:0], mosi_s};
                    end
                end
            end
            DRAIN: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end else if (bit_in) begin
                    cnt_d = cnt_inc;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (is_cmd_q) begin
                    hi_d   = shift_q[CMD_BITS-1:CMD_BITS-HI_W];
                    type_d = shift_q[LO_W+1:LO_W];
                    lo_d   = shift_q[LO_W-1:0];
                    wr_d   = 1'b1;
                end else begin
                    time_d = shift_q[TIME_BITS-1:0];
                    upd_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // Sync flops reset low so a CS_n already low at reset release is not an edge
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sck_q    <= '0;
            cs_q     <= '0;
            mosi_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            is_cmd_q <= 1'b0;
            hi_q     <= '0;
            type_q   <= '0;
            lo_q     <= '0;
            time_q   <= '0;
            upd_q    <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= '0;
        end else begin
            sck_q    <= {sck_q[1:0], SCK};
            cs_q     <= {cs_q[1:0], CS_n};
            mosi_q   <= {mosi_q[0], MOSI};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            is_cmd_q <= is_cmd_d;
            hi_q     <= hi_d;
            type_q   <= type_d;
            lo_q     <= lo_d;
            time_q   <= time_d;
            upd_q    <= upd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end

    assign FREQ            = hi_q[207:160];
    assign FREQ_STEP       = hi_q[159:112];
    assign FREQ_RATE       = hi_q[111:80];
    assign TIME_START      = hi_q[79:16];
    assign N_impulse       = hi_q[15:0];
    assign TYPE_impulse    = type_q;
    assign Interval_Ti     = lo_q[127:96];
    assign Interval_Tp     = lo_q[95:64];
    assign Tblank1         = lo_q[63:32];
    assign Tblank2         = lo_q[31:0];
    assign SPI_WR          = wr_q;
    assign TIME_INIT       = time_q;
    assign SYS_TIME_UPDATE = upd_q;
    assign ERR_CNT         = err_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Randomized self-checking bench for spi_cmd_rx against a frame-level model.
`timescale 1ns/1ps
module tb_spi_cmd_rx;

    logic        CLK = 1'b0;
    logic        rst_n, SCK, CS_n, MOSI, SYS_TIME_UPDATE_OK;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic        SPI_WR;
    logic [63:0] TIME_INIT;
    logic        SYS_TIME_UPDATE;
    logic [7:0]  ERR_CNT;

    spi_cmd_rx dut (
        .CLK(CLK), .rst_n(rst_n), .SCK(SCK), .CS_n(CS_n), .MOSI(MOSI),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK),
        .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
        .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
        .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR),
        .TIME_INIT(TIME_INIT), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [47:0] freq, step;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [7:0]  typ;
        logic [31:0] ti, tp, b1, b2;
    } cmd_t;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_total = 0;
    int wr_lat;

    // Reference model state
    cmd_t        m_cmd;
    logic [63:0] m_time;
    logic        m_upd;
    int          m_err;

    always @(negedge CLK) if (SPI_WR === 1'b1) wr_total++;

    function automatic logic [343:0] pack_cmd(input cmd_t c);
        return {c.freq, c.step, c.rate, c.tstart, c.n, c.typ, c.ti, c.tp, c.b1, c.b2};
    endfunction

    function automatic logic [343:0] exp_cmd();
        return {m_cmd.freq, m_cmd.step, m_cmd.rate, m_cmd.tstart, m_cmd.n,
                6'b0, m_cmd.typ[1:0], m_cmd.ti, m_cmd.tp, m_cmd.b1, m_cmd.b2};
    endfunction

    function automatic logic [343:0] obs_cmd();
        return {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
                6'b0, TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.freq   = 48'({$urandom, $urandom});
        c.step   = 48'({$urandom, $urandom});
        c.rate   = $urandom;
        c.tstart = {$urandom, $urandom};
        c.n      = 16'($urandom);
        c.typ    = 8'($urandom);
        c.ti     = $urandom;
        c.tp     = $urandom;
        c.b1     = $urandom;
        c.b2     = $urandom;
        return c;
    endfunction

    function automatic void model_reset();
        m_cmd  = '{default: '0};
        m_time = '0;
        m_upd  = 1'b0;
        m_err  = 0;
    endfunction

    // Frame-level rules: exact-length known opcode commits, anything else is one error
    function automatic int model_frame(input logic [7:0] opc, input int npay,
                                       input cmd_t c, input logic [63:0] t);
        if (opc == 8'h01 && npay == 344) begin
            m_cmd = c;
            return 1;
        end
        if (opc == 8'h02 && npay == 64) begin
            m_time = t;
            m_upd  = 1'b1;
            return 0;
        end
        if (m_err < 255) m_err++;
        return 0;
    endfunction

    task automatic send_bit(input logic b);
        MOSI = b;
        repeat (4) @(negedge CLK);
        SCK = 1'b1;
        repeat (4) @(negedge CLK);
        SCK = 1'b0;
    endtask

    // Sends opcode then the low npay bits of pl MSB first; ok_at pulses the
    // time-applied input on that clock after the CS_n pin goes high
    task automatic send_frame(input logic [7:0] opc, input int npay,
                              input logic [399:0] pl, input int ok_at);
        @(negedge CLK);
        CS_n = 1'b0;
        repeat (4) @(negedge CLK);
        for (int i = 7; i >= 0; i--) send_bit(opc[i]);
        for (int i = npay - 1; i >= 0; i--) send_bit(pl[i]);
        repeat (4) @(negedge CLK);
        CS_n   = 1'b1;
        wr_lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            SYS_TIME_UPDATE_OK = (k == ok_at);
            if (SPI_WR === 1'b1 && wr_lat < 0) wr_lat = k;
        end
        SYS_TIME_UPDATE_OK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [416:0] all_out;
        rst_n = 1'b0; SCK = 1'b0; CS_n = 1'b0; MOSI = 1'b0; SYS_TIME_UPDATE_OK = 1'b0;
        model_reset();
        repeat (5) @(negedge CLK);
        all_out = {obs_cmd(), TIME_INIT, SYS_TIME_UPDATE, SPI_WR, ERR_CNT};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) send_bit(1'($urandom));
        repeat (4) @(negedge CLK);
        CS_n = 1'b1;
        repeat (12) @(negedge CLK);
        n_checks++;
        if (ERR_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cs_low_err: got %0d expected 0", ERR_CNT);
        end
        n_checks++;
        if (wr_total !== 0 || obs_cmd() !== '0) begin
            n_fail++;
            $display("FAIL reset_cs_low_wr: got %0d strobes expected 0", wr_total);
        end
    endtask

    task automatic test_cmd_frame();
        cmd_t c;
        int   w0, ew;
        c = '{freq: 48'h001000000000, step: 48'h000000100000, rate: 32'h100,
              tstart: 64'h22C0, n: 16'd1, typ: 8'h01, ti: 32'h1800, tp: 32'h1800,
              b1: 32'h180, b2: 32'h180};
        w0 = wr_total;
        send_frame(8'h01, 344, 400'(pack_cmd(c)), 0);
        ew = model_frame(8'h01, 344, c, '0);
        n_checks++;
        if (wr_total - w0 !== ew) begin
            n_fail++;
            $display("FAIL cmd_wr_count: got %0d expected %0d", wr_total - w0, ew);
        end
        n_checks++;
        if (wr_lat !== 4) begin
            n_fail++;
            $display("FAIL cmd_wr_latency: got %0d expected 4", wr_lat);
        end
        n_checks++;
        if (obs_cmd() !== exp_cmd()) begin
            n_fail++;
            $display("FAIL cmd_fields: got %h expected %h", obs_cmd(), exp_cmd());
        end
        n_checks++;
        if (ERR_CNT !== 8'(m_err) || SYS_TIME_UPDATE !== m_upd) begin
            n_fail++;
            $display("FAIL cmd_status: got err %0d upd %b expected err %0d upd %b",
                     ERR_CNT, SYS_TIME_UPDATE, m_err, m_upd);
        end
    endtask

    task automatic test_time_frame();
        int w0, ew;
        w0 = wr_total;
        send_frame(8'h02, 64, '0, 0);
        ew = model_frame(8'h02, 64, m_cmd, 64'h0);
        n_checks++;
        if (wr_total - w0 !== ew || SYS_TIME_UPDATE !== m_upd || TIME_INIT !== m_time) begin
            n_fail++;
            $display("FAIL time_commit: got wr %0d upd %b init %h expected wr %0d upd %b init %h",
                     wr_total - w0, SYS_TIME_UPDATE, TIME_INIT, ew, m_upd, m_time);
        end
        repeat (1000) @(negedge CLK);
        n_checks++;
        if (SYS_TIME_UPDATE !== 1'b1) begin
            n_fail++;
            $display("FAIL time_pending_hold: got %b expected 1", SYS_TIME_UPDATE);
        end
        SYS_TIME_UPDATE_OK = 1'b1;
        @(negedge CLK);
        SYS_TIME_UPDATE_OK = 1'b0;
        m_upd = 1'b0;
        n_checks++;
        if (SYS_TIME_UPDATE !== m_upd) begin
            n_fail++;
            $display("FAIL time_ok_clear: got %b expected %b", SYS_TIME_UPDATE, m_upd);
        end
    endtask

    task automatic test_errors();
        cmd_t c;
        int   w0, ew;
        int   lens[3] = '{200, 345, 0};
        logic [7:0] opcs[3] = '{8'h01, 8'h01, 8'h7F};
        logic [399:0] pl;
        c = rand_cmd();
        for (int i = 0; i < 3; i++) begin
            pl = (lens[i] == 345) ? {55'b0, pack_cmd(c), 1'b1} : 400'(pack_cmd(c) >> 144);
            w0 = wr_total;
            send_frame(opcs[i], lens[i], pl, 0);
            ew = model_frame(opcs[i], lens[i], c, '0);
            n_checks++;
            if (wr_total - w0 !== ew || obs_cmd() !== exp_cmd()) begin
                n_fail++;
                $display("FAIL err_frame%0d_outputs: got wr %0d fields %h expected wr %0d fields %h",
                         i, wr_total - w0, obs_cmd(), ew, exp_cmd());
            end
            n_checks++;
            if (ERR_CNT !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL err_frame%0d_count: got %0d expected %0d", i, ERR_CNT, m_err);
            end
        end
    endtask

    task automatic test_err_saturate();
        logic [7:0] opc;
        int ew;
        for (int i = 0; i < 260; i++) begin
            opc = 8'($urandom_range(3, 255));
            send_frame(opc, 0, '0, 0);
            ew = model_frame(opc, 0, m_cmd, '0);
        end
        n_checks++;
        if (ERR_CNT !== 8'(m_err) || m_err != 255) begin
            n_fail++;
            $display("FAIL err_saturate: got %0d expected %0d", ERR_CNT, m_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [416:0] all_out;
        cmd_t c;
        int   w0, ew;
        @(negedge CLK);
        CS_n = 1'b0;
        repeat (4) @(negedge CLK);
        for (int i = 7; i >= 0; i--) send_bit(i == 0);
        for (int i = 0; i < 100; i++) send_bit(1'($urandom));
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        all_out = {obs_cmd(), TIME_INIT, SYS_TIME_UPDATE, SPI_WR, ERR_CNT};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge CLK);
        CS_n = 1'b1;
        repeat (12) @(negedge CLK);
        c = rand_cmd();
        c.tstart = 64'h92C0;
        w0 = wr_total;
        send_frame(8'h01, 344, 400'(pack_cmd(c)), 0);
        ew = model_frame(8'h01, 344, c, '0);
        n_checks++;
        if (wr_total - w0 !== ew || TIME_START !== 64'h92C0 || obs_cmd() !== exp_cmd()) begin
            n_fail++;
            $display("FAIL midreset_frame: got wr %0d fields %h expected wr %0d fields %h",
                     wr_total - w0, obs_cmd(), ew, exp_cmd());
        end
        n_checks++;
        if (ERR_CNT !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL midreset_err: got %0d expected %0d", ERR_CNT, m_err);
        end
    endtask

    task automatic test_random_frames();
        cmd_t c;
        logic [63:0]  t;
        logic [7:0]   opc;
        logic [399:0] pl;
        int kind, npay, exact, w0, ew;
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 3);
            c = rand_cmd();
            t = {$urandom, $urandom};
            for (int i = 0; i < 400; i++) pl[i] = 1'($urandom);
            case (kind)
                0: begin opc = 8'h01; npay = 344; pl = 400'(pack_cmd(c)); end
                1: begin opc = 8'h02; npay = 64;  pl = 400'(t); end
                2: begin
                    opc   = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
                    exact = (opc == 8'h01) ? 344 : 64;
                    npay  = $urandom_range(0, exact + 1);
                    if (npay == exact) npay = exact + 1;
                end
                default: begin opc = 8'($urandom_range(3, 255)); npay = $urandom_range(0, 40); end
            endcase
            w0 = wr_total;
            send_frame(opc, npay, pl, 0);
            ew = model_frame(opc, npay, c, t);
            n_checks++;
            if (wr_total - w0 !== ew || obs_cmd() !== exp_cmd()) begin
                n_fail++;
                $display("FAIL rand%0d_cmd op %h len %0d: got wr %0d fields %h expected wr %0d fields %h",
                         it, opc, npay, wr_total - w0, obs_cmd(), ew, exp_cmd());
            end
            n_checks++;
            if (TIME_INIT !== m_time || SYS_TIME_UPDATE !== m_upd || ERR_CNT !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL rand%0d_time op %h len %0d: got init %h upd %b err %0d expected init %h upd %b err %0d",
                         it, opc, npay, TIME_INIT, SYS_TIME_UPDATE, ERR_CNT, m_time, m_upd, m_err);
            end
        end
    endtask

    task automatic test_time_ok_collide();
        logic [63:0] t1, t2, t3;
        int ew;
        t1 = {$urandom, $urandom};
        t2 = {$urandom, $urandom};
        t3 = {$urandom, $urandom};
        send_frame(8'h02, 64, 400'(t1), 0);
        ew = model_frame(8'h02, 64, m_cmd, t1);
        // Pin edge + 4 clocks is the commit; OK driven on clock 3 lands on it
        send_frame(8'h02, 64, 400'(t2), 3);
        ew = model_frame(8'h02, 64, m_cmd, t2);
        n_checks++;
        if (SYS_TIME_UPDATE !== m_upd || TIME_INIT !== m_time) begin
            n_fail++;
            $display("FAIL collide: got upd %b init %h expected upd %b init %h",
                     SYS_TIME_UPDATE, TIME_INIT, m_upd, m_time);
        end
        send_frame(8'h02, 64, 400'(t3), 6);
        ew = model_frame(8'h02, 64, m_cmd, t3);
        m_upd = 1'b0;
        n_checks++;
        if (SYS_TIME_UPDATE !== m_upd || TIME_INIT !== m_time) begin
            n_fail++;
            $display("FAIL ok_after_commit: got upd %b init %h expected upd %b init %h",
                     SYS_TIME_UPDATE, TIME_INIT, m_upd, m_time);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_frame();
        test_time_frame();
        test_errors();
        test_err_saturate();
        test_reset_mid_frame();
        test_random_frames();
        test_time_ok_collide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
